// File: rtl/lc_bank_pkg.sv
// Shared types and defaults for the lumped C/L tuning bank sequencer.
package lc_bank_pkg;

    localparam int N_C_DEF        = 8;
    localparam int N_L_DEF        = 4;
    localparam int BREAK_CYC_DEF  = 4;
    localparam int SETTLE_CYC_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BREAK = 2'd1,
        MAKE  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Width able to hold max_cyc-1; never narrower than one bit.
    function automatic int timer_w(input int max_cyc);
        return (max_cyc > 2) ? $clog2(max_cyc) : 1;
    endfunction

endpackage

// File: rtl/lc_bank_timer.sv
// Loadable down-counter shared by the break dead-time and the settle phase.
module lc_bank_timer
    import lc_bank_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    // Saturates at zero: only counts down while nonzero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/lc_bank_seq.sv
// Arbitrates host/loop tuning requests and applies the new C/L code to the
// switch bank with break-before-make ordering.
module lc_bank_seq
    import lc_bank_pkg::*;
#(
    parameter int N_C        = N_C_DEF,
    parameter int N_L        = N_L_DEF,
    parameter int BREAK_CYC  = BREAK_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           host_valid,
    input  logic [N_C-1:0] host_c,
    input  logic [N_L-1:0] host_l,
    output logic           host_ready,
    input  logic           loop_valid,
    input  logic [N_C-1:0] loop_c,
    input  logic [N_L-1:0] loop_l,
    output logic           loop_ready,
    output logic [N_C-1:0] sw_c,
    output logic [N_L-1:0] sw_l,
    output logic           busy,
    output logic           done,
    output logic           grant_host
);

    localparam int NB = N_C + N_L;
    localparam int TW = timer_w((BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC);
    localparam logic [TW-1:0] BREAK_LD  = TW'(BREAK_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);

    state_t          state_reg, state_next;
    logic [NB-1:0]   cur_reg, cur_next;
    logic [NB-1:0]   tgt_reg, tgt_next;
    logic [NB-1:0]   sw_reg, sw_next;
    logic            grant_reg, grant_next;
    logic            done_reg, busy_reg;
    logic            t_load, t_zero;
    logic [TW-1:0]   t_val;
    logic            acc_host, acc_loop;
    logic [NB-1:0]   req;

    assign host_ready = (state_reg == IDLE);
    assign loop_ready = (state_reg == IDLE) & ~host_valid;
    assign acc_host   = host_valid & host_ready;
    assign acc_loop   = loop_valid & loop_ready;
    assign req        = acc_host ? {host_c, host_l} : {loop_c, loop_l};

    lc_bank_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        tgt_next   = tgt_reg;
        sw_next    = sw_reg;
        grant_next = grant_reg;
        t_load     = 1'b0;
        t_val      = '0;
        case (state_reg)
            IDLE: begin
                if (acc_host | acc_loop) begin
                    tgt_next   = req;
                    grant_next = acc_host;
                    if (req == cur_reg) begin
                        state_next = DONE;
                    end else if ((cur_reg & ~req) != '0) begin
                        // Open only the bits being dropped; keep shared bits closed.
                        state_next = BREAK;
                        sw_next    = cur_reg & req;
                        t_load     = 1'b1;
                        t_val      = BREAK_LD;
                    end else begin
                        state_next = MAKE;
                        sw_next    = req;
                        t_load     = 1'b1;
                        t_val      = SETTLE_LD;
                    end
                end
            end
            BREAK: begin
                if (t_zero) begin
                    state_next = MAKE;
                    sw_next    = tgt_reg;
                    t_load     = 1'b1;
                    t_val      = SETTLE_LD;
                end
            end
            MAKE: begin
                if (t_zero) begin
                    state_next = DONE;
                    cur_next   = tgt_reg;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            tgt_reg   <= '0;
            sw_reg    <= '0;
            grant_reg <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            tgt_reg   <= tgt_next;
            sw_reg    <= sw_next;
            grant_reg <= grant_next;
            done_reg  <= (state_next == DONE);
            busy_reg  <= (state_next != IDLE);
        end
    end

    assign sw_c       = sw_reg[NB-1:N_L];
    assign sw_l       = sw_reg[N_L-1:0];
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign grant_host = grant_reg;

endmodule
